// File: rtl/pad_poll_scheduler.sv
// Two-pad serial controller poller: latches both pads, clocks out 8 bits each,
// then publishes the button state and newly-pressed edges once per frame.
module pad_poll_scheduler #(
  parameter int HALF_BIT    = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       force_poll,
  input  logic       clr_overrun,
  input  logic       data_a,
  input  logic       data_b,
  output logic       latch,
  output logic       pulse,
  output logic [7:0] buttons_a,
  output logic [7:0] buttons_b,
  output logic [7:0] pressed_a,
  output logic [7:0] pressed_b,
  output logic       valid,
  output logic       busy,
  output logic       overrun
);

  localparam int PHASE_W = $clog2(2 * HALF_BIT);
  localparam int POLL_W  = $clog2(POLL_PERIOD);
  localparam int BIT_W   = $clog2(9);

  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_BIT - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_BIT - 1);
  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(7);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    PULSE_HI,
    PULSE_LO,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [POLL_W-1:0]  poll_cnt;
  logic [PHASE_W-1:0] phase_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [7:0]         shift_a;
  logic [7:0]         shift_b;
  logic               tick;
  logic               sample;

  assign tick  = (poll_cnt == POLL_LAST);
  assign latch = (state == LATCH);
  assign pulse = (state == PULSE_HI);
  assign busy  = (state != IDLE);

  // Free-running poll timebase, independent of the frame engine.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      poll_cnt <= '0;
    end else if (tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + POLL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Samples are taken on the last cycle of LATCH and of every PULSE_LO.
  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (tick || force_poll)) state_next = LATCH;
      end
      LATCH: begin
        if (phase_cnt == LATCH_LAST) begin
          sample     = 1'b1;
          state_next = PULSE_HI;
        end
      end
      PULSE_HI: begin
        if (phase_cnt == HALF_LAST) state_next = PULSE_LO;
      end
      PULSE_LO: begin
        if (phase_cnt == HALF_LAST) begin
          sample     = 1'b1;
          state_next = (bit_cnt == LAST_BIT) ? DONE : PULSE_HI;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shift_a   <= '0;
      shift_b   <= '0;
    end else begin
      if (state == IDLE || state_next != state) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + PHASE_W'(1);
      end
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (sample) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (sample) begin
        shift_a <= {shift_a[6:0], ~data_a};
        shift_b <= {shift_b[6:0], ~data_b};
      end
    end
  end

  // Publish on the edge leaving DONE; pressed compares against the previous frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buttons_a <= '0;
      buttons_b <= '0;
      pressed_a <= '0;
      pressed_b <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= (state == DONE);
      if (state == DONE) begin
        buttons_a <= shift_a;
        buttons_b <= shift_b;
        pressed_a <= shift_a & ~buttons_a;
        pressed_b <= shift_b & ~buttons_b;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun <= 1'b0;
    end else if (tick && enable && state != IDLE) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: doc/pad_poll_scheduler.md
PAD_POLL_SCHEDULER -- requirements
Module: pad_poll_scheduler

Interface
REQ-001 Parameter HALF_BIT, default 300, is the half-period of the serial pulse in clk cycles (6 us at 50 MHz); legal range is HALF_BIT >= 1.
REQ-002 Parameter POLL_PERIOD, default 833333, is the automatic poll interval in clk cycles (60 Hz); legal range is POLL_PERIOD > 16*HALF_BIT+1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  permits frame starts from the poll tick or from force_poll.
REQ-006 force_poll  input  1  one-cycle request for an immediate frame.
REQ-007 clr_overrun  input  1  synchronous clear of the overrun flag.
REQ-008 data_a, data_b  input  1 each  serial pad data, active-low (0 = pressed), one line per pad.
REQ-009 latch  output  1  shared pad latch strobe.
REQ-010 pulse  output  1  shared pad shift clock.
REQ-011 buttons_a, buttons_b  output  8 each  last complete frame per pad, 1 = pressed; bit 7 is the first bit shifted in.
REQ-012 pressed_a, pressed_b  output  8 each  newly pressed flags from the last frame.
REQ-013 valid  output  1  one-cycle strobe when the buttons and pressed outputs update.
REQ-014 busy  output  1  frame in progress.
REQ-015 overrun  output  1  sticky flag: a poll tick arrived while busy.

Function
REQ-016 The FSM SHALL have the states IDLE, LATCH, PULSE_HI, PULSE_LO and DONE; busy SHALL be 1 in every state except IDLE.
REQ-017 The poll counter SHALL count 0..POLL_PERIOD-1 and wrap, every cycle and in every state; a tick SHALL occur in the cycle the counter equals POLL_PERIOD-1.
REQ-018 In IDLE, with enable=1 and either a tick or force_poll, the FSM SHALL enter LATCH on the next edge; a tick together with force_poll SHALL start exactly one frame.
REQ-019 With enable=0, the FSM SHALL stay in IDLE; ticks SHALL neither start frames nor set overrun.
REQ-020 force_poll SHALL be ignored when not in IDLE.
REQ-021 LATCH: latch=1 and pulse=0 for 2*HALF_BIT cycles; on the last cycle, ~data_a and ~data_b SHALL be shifted into the per-pad shift registers; the next state SHALL be PULSE_HI.
REQ-022 PULSE_HI: pulse=1 and latch=0 for HALF_BIT cycles; the next state SHALL be PULSE_LO.
REQ-023 PULSE_LO: pulse=0 and latch=0 for HALF_BIT cycles; on the last cycle, ~data_a and ~data_b SHALL be shifted in and the bit count incremented; the next state SHALL be DONE after the 8th sample, otherwise PULSE_HI.
REQ-024 Shifting SHALL go MSB-first: each sample enters bit 0 and earlier bits move toward bit 7, so the first sample ends up in bit 7.
REQ-025 A frame SHALL contain exactly 7 pulse high phases and SHALL take 16*HALF_BIT cycles from LATCH entry to DONE entry.
REQ-026 DONE SHALL last one cycle; on the edge leaving DONE the outputs SHALL update as follows: buttons_x <= shift_x; pressed_x <= shift_x & ~buttons_x(old); valid=1 for that one cycle.
REQ-027 After DONE, the FSM SHALL return to IDLE.
REQ-028 pressed_x SHALL hold its value until the next valid strobe.
REQ-029 A tick in any busy state (including DONE) with enable=1 SHALL set overrun and SHALL NOT start or restart a frame.
REQ-030 overrun SHALL clear only on clr_overrun=1; if clr_overrun and a set event occur in the same cycle, set SHALL win.
REQ-031 If enable is dropped mid-frame, the frame SHALL still complete and update the outputs.
REQ-032 The phase, bit and poll counters SHALL be sized with $clog2 of their maximum count; no counter SHALL overflow within the legal parameter range.

Reset
REQ-033 While n_rst=0, all outputs SHALL be 0 (latch, pulse, valid, busy, overrun, buttons_a/b, pressed_a/b) and the FSM SHALL be in IDLE.
REQ-034 While n_rst=0, the poll counter, phase counter, bit counter and shift registers SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, driving latch and pulse low asynchronously; no valid strobe SHALL follow.
REQ-036 After release, the first tick SHALL occur POLL_PERIOD cycles later.

Verification (HALF_BIT=2, POLL_PERIOD=40)
REQ-037 force_poll, data_a held 0, data_b held 1 -> latch high 4 cycles, 7 pulses each 2 high / 2 low, valid 33 cycles after LATCH entry; buttons_a=FF, buttons_b=00, pressed_a=FF.
REQ-038 data_a driven per sample 0,1,1,1,1,1,1,0 -> buttons_a=81; the next frame with all samples 0 -> buttons_a=FF, pressed_a=7E.
REQ-039 force_poll raised 5 cycles into a frame -> ignored; exactly one valid strobe.
REQ-040 POLL_PERIOD=20 (illegal, used as a stress case), free running -> overrun=1; clr_overrun together with a tick -> overrun remains 1; clr_overrun alone -> 0.
REQ-041 n_rst pulsed low during PULSE_HI -> latch, pulse and busy are 0 immediately; buttons are 00; no valid strobe.
REQ-042 enable=0 across 3 poll periods -> no latch activity and overrun stays 0; enable dropped mid-frame -> the frame completes with valid=1.
